// File: rtl/image_loader.sv
// Binarizes a raster pixel stream into a double-buffered NPIX-bit image; image_valid rises the cycle after the last pixel is accepted.
// Backpressure: only the final pixel of a frame stalls (s_ready low) while the previous image is still unacknowledged.
module image_loader #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 128,
  parameter int NPIX        = IMG_W * IMG_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                   s_sof,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [NPIX-1:0]        image_out,
  output logic                   image_valid,
  input  logic                   image_ack,
  output logic                   frame_error,
  output logic [15:0]            frame_count
);

  localparam int IDX_W = $clog2(NPIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, wr_idx;
  logic [NPIX-1:0]  cap_buf;
  logic             xfer, pix_bit, wr_en, last_xfer, err_nxt;

  // Depends on registered state only, so image_ack never reaches s_ready combinationally.
  assign s_ready = !(state == LOAD && idx == LAST_IDX && image_valid);
  assign xfer    = s_valid && s_ready;
  assign pix_bit = (s_pixel >= PIXEL_WIDTH'(THRESHOLD));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_idx    = idx;
    wr_en     = 1'b0;
    last_xfer = 1'b0;
    err_nxt   = 1'b0;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (s_sof) begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            idx_nxt   = IDX_W'(1);
            state_nxt = LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
        LOAD: begin
          if (s_sof) begin
            // Restart: stale bits get overwritten before the frame can complete.
            err_nxt = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = '0;
            idx_nxt = IDX_W'(1);
          end else if (idx == LAST_IDX) begin
            wr_en     = 1'b1;
            last_xfer = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            wr_en   = 1'b1;
            idx_nxt = idx + IDX_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      cap_buf     <= '0;
      image_out   <= '0;
      image_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      idx         <= idx_nxt;
      frame_error <= err_nxt;
      if (wr_en) cap_buf[wr_idx] <= pix_bit;
      // The final bit bypasses the capture buffer so image_out is complete on the same edge.
      if (last_xfer) begin
        image_out   <= {pix_bit, cap_buf[NPIX-2:0]};
        image_valid <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end else if (image_ack && image_valid) begin
        image_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with a scoreboard of expected images popped on each image_valid rise.
module tb_image_loader;
  localparam int NPIX = 784;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      s_pixel = '0;
  logic            s_sof = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [NPIX-1:0] image_out;
  logic            image_valid;
  logic            image_ack = 1'b0;
  logic            frame_error;
  logic [15:0]     frame_count;

  typedef struct packed {
    logic [NPIX-1:0] img;
    logic [15:0]     cnt;
  } exp_t;

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              err_seen = 0;
  int              exp_count = 0;
  logic            prev_valid = 1'b0;
  logic [NPIX-1:0] held = '0;

  image_loader dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .image_out(image_out), .image_valid(image_valid),
    .image_ack(image_ack), .frame_error(frame_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] pix_of(input int kind, input int k);
    int h;
    case (kind)
      0: return (k % 2 == 0) ? 8'd200 : 8'd50;
      1: return (k == 0) ? 8'd127 : (k == 1) ? 8'd128 : (k == 2) ? 8'd255 : 8'd0;
      2: return 8'd255;
      3: return 8'd0;
      default: begin
        h = (k * 73 + kind * 29) ^ (k >> 2);
        return h[7:0];
      end
    endcase
  endfunction

  function automatic logic [NPIX-1:0] exp_img(input int kind);
    logic [NPIX-1:0] img;
    img = '0;
    for (int k = 0; k < NPIX; k++) img[k] = (pix_of(kind, k) >= 8'd128);
    return img;
  endfunction

  // Offers one pixel and waits (bounded) for the edge that takes it; returns #1 after that edge.
  task automatic push_pix(input logic [7:0] p, input logic sof);
    logic r;
    int   guard;
    guard   = 0;
    s_pixel = p;
    s_sof   = sof;
    s_valid = 1'b1;
    do begin
      r = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!r && guard < 2000);
    check("pix_accept", r, 1);
    if (frame_error) err_seen++;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic stream(input int kind, input int first, input int last);
    for (int k = first; k <= last; k++) push_pix(pix_of(kind, k), k == 0);
  endtask

  task automatic send_frame(input int kind);
    exp_t e;
    exp_count++;
    e.img = exp_img(kind);
    e.cnt = 16'(exp_count);
    sb.push_back(e);
    stream(kind, 0, NPIX - 1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_sof     = 1'b0;
    image_ack = 1'b0;
    @(posedge clk);
    #1;
    check("rst_image_out", image_out, 0);
    check("rst_image_valid", image_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    sb.delete();
    exp_count = 0;
    err_seen  = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (image_valid && !prev_valid) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL sb_unexpected_image observed=image_valid expected=no_image");
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_image", image_out, e.img);
          check("sb_count", frame_count, e.cnt);
          held = image_out;
        end
      end else if (image_valid && prev_valid) begin
        check("image_stable", image_out, held);
      end
      prev_valid = image_valid;
    end
  end

  initial begin
    // Reset values
    do_reset();

    // Alternating 200/50 frame, ack held high
    image_ack = 1'b1;
    send_frame(0);
    check("alt_valid_rise", image_valid, 1);
    check("alt_count", frame_count, 1);
    check("alt_image", image_out, exp_img(0));
    check("alt_err", err_seen, 0);
    @(posedge clk);
    #1;
    check("alt_valid_consumed", image_valid, 0);

    // Threshold boundary 127/128/255
    send_frame(1);
    check("thr_low3", image_out[2:0], 3'b110);
    check("thr_full", image_out, 3'b110);
    check("thr_count", frame_count, 2);

    // Stray pixel in IDLE, then a proper frame
    do_reset();
    image_ack = 1'b1;
    push_pix(8'd200, 1'b0);
    check("stray_err_pulse", err_seen, 1);
    check("stray_count", frame_count, 0);
    check("stray_valid", image_valid, 0);
    @(posedge clk);
    #1;
    check("stray_err_clear", frame_error, 0);
    send_frame(0);
    check("stray_frame_count", frame_count, 1);
    check("stray_err_total", err_seen, 1);

    // Restart after 300 bright pixels
    do_reset();
    image_ack = 1'b1;
    stream(2, 0, 299);
    send_frame(3);
    check("restart_err", err_seen, 1);
    check("restart_image", image_out, 0);
    check("restart_count", frame_count, 1);

    // Back-to-back with late ack
    do_reset();
    send_frame(4);
    check("b2b_a_valid", image_valid, 1);
    stream(5, 0, NPIX - 2);
    check("b2b_stall_ready", s_ready, 0);
    check("b2b_hold_a", image_out, exp_img(4));
    begin
      exp_t e;
      exp_count++;
      e.img = exp_img(5);
      e.cnt = 16'(exp_count);
      sb.push_back(e);
    end
    s_pixel = pix_of(5, NPIX - 1);
    s_sof   = 1'b0;
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("b2b_stall_ready_hold", s_ready, 0);
      check("b2b_stall_valid", image_valid, 1);
      check("b2b_stall_image", image_out, exp_img(4));
    end
    image_ack = 1'b1;
    @(posedge clk);
    #1;
    image_ack = 1'b0;
    check("b2b_valid_fall", image_valid, 0);
    check("b2b_ready_back", s_ready, 1);
    check("b2b_image_still_a", image_out, exp_img(4));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("b2b_b_valid", image_valid, 1);
    check("b2b_b_image", image_out, exp_img(5));
    check("b2b_count", frame_count, 2);

    // Reset mid-frame while an image is held
    do_reset();
    send_frame(0);
    check("midrst_held", image_valid, 1);
    stream(2, 0, 399);
    do_reset();
    image_ack = 1'b1;
    send_frame(4);
    check("midrst_count", frame_count, 1);
    check("midrst_image", image_out, exp_img(4));

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream stage of the digit-classifier pipeline.
- Accepts a raster stream of 8-bit grayscale pixels over a valid/ready handshake and binarizes each pixel against a threshold.
- Assembles the bits into the 784-bit flat input image consumed by the CNN top, then presents it with a valid/ack handshake.
- Double-buffered: the next frame loads while the current image is held stable for the CNN.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
PIXEL_WIDTH, 8, bits per incoming grayscale pixel
THRESHOLD, 128, binarization threshold; bit = (pixel >= THRESHOLD), unsigned compare
NPIX, IMG_W*IMG_H, derived; total pixels per frame and width of image_out

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
s_pixel  input  PIXEL_WIDTH  grayscale pixel, unsigned
s_sof  input  1  start of frame; qualifies the first pixel of a frame
s_valid  input  1  pixel valid
s_ready  output  1  loader can accept a pixel
image_out  output  NPIX  binarized image; bit k = pixel k in raster order (k = row*IMG_W + col, bit 0 = first pixel)
image_valid  output  1  image_out holds a complete, unconsumed frame
image_ack  input  1  consumer has taken image_out
frame_error  output  1  one-cycle pulse on a protocol error
frame_count  output  16  completed frames, wraps at 65535 -> 0

Behaviour:
- Reset values:
  - Outputs: image_out = 0, image_valid = 0, frame_error = 0, frame_count = 0, s_ready = 1.
  - Internal: state = IDLE, idx = 0, capture buffer = 0.
- Reset mid-frame discards the partial frame and any held image.
- Transfer: occurs when s_valid && s_ready at a rising edge. There are no transfers when s_ready = 0.
- Capture buffer: separate from the image_out register. Bit idx <= (s_pixel >= THRESHOLD) on each accepted transfer.
- States:
  - IDLE (awaiting frame start):
    - Transfer with s_sof = 1: write bit 0, idx <= 1, go to LOAD.
    - Transfer with s_sof = 0: pixel dropped, frame_error pulses next cycle, stay in IDLE.
  - LOAD (frame in progress):
    - Transfer with s_sof = 0 and idx < NPIX-1: write bit idx, idx <= idx+1.
    - Transfer with s_sof = 1: frame restart. frame_error pulses, the pixel is written as bit 0, idx <= 1. Stale bits from the aborted frame are overwritten as loading proceeds and are never exposed.
    - Transfer at idx == NPIX-1 (s_sof = 0): frame complete. The same edge writes the final bit and copies the full buffer, including that final bit, into image_out. image_valid <= 1, frame_count <= frame_count+1, idx <= 0, go to IDLE.
    - The first cycle image_out is readable is the cycle after the final transfer.
- s_ready: s_ready = !(state == LOAD && idx == NPIX-1 && image_valid).
  - s_ready is registered-state-only; there is no combinational path from image_ack.
  - The final pixel of a frame stalls while the previous image is unconsumed.
- Consume: image_ack && image_valid clears image_valid on the next edge. image_ack while image_valid = 0 is ignored.
  - A stalled final pixel is accepted no earlier than the cycle after image_valid falls.
- image_out is stable for the whole time image_valid = 1.
- Simultaneous ack and final transfer: impossible by the s_ready rule.
- frame_error never affects image_valid or frame_count.
- Latency: the last pixel accepted on edge N gives image_valid = 1 from edge N onward (visible in cycle N+1).

Test Plan:
- Full frame, one pixel per cycle: pixel k = 200 if k even, else 50; ack held 1 -> image_valid rises the cycle after pixel 783; image_out = 0x...5555 (bit k = 1 for even k); frame_count = 1; s_ready stays 1.
- Threshold boundary: pixel 0 = 127, pixel 1 = 128, pixel 2 = 255, rest 0 -> image_out[2:0] = 3'b110, all other bits 0.
- Stray pixel while IDLE with s_sof = 0 -> frame_error one-cycle pulse; no state change; a following proper 784-pixel frame completes normally with frame_count = 1.
- Restart: 300 pixels of 255, then s_sof with a new 784-pixel frame of 0 -> one frame_error pulse; image_out all 0 (no stale 1s); frame_count = 1.
- Back-to-back with late ack: frame A complete, ack held low; frame B streamed continuously -> s_ready drops with idx = 783; image_out stays A; raise ack for 1 cycle -> image_valid falls, B's final pixel accepted next, image_out = B, frame_count = 2.
- Reset at pixel 400 of a frame with image_valid = 1 -> all outputs at reset values next cycle; a subsequent full frame yields frame_count = 1.
